// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: shadows A/B on start, walks them MSB-first
// through a 1-bit eq/gt/lt cascade for WIDTH cycles, then publishes a registered result.
module serial_mag_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_eq,
  output logic             o_gt,
  output logic             o_lt
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state;
  logic [WIDTH-1:0] r_a, w_a;
  logic [WIDTH-1:0] r_b, w_b;
  logic [IdxW-1:0]  r_idx, w_idx;
  logic             r_eq_c, w_eq_c;
  logic             r_gt_c, w_gt_c;
  logic             r_lt_c, w_lt_c;
  logic             r_eq, w_eq;
  logic             r_gt, w_gt;
  logic             r_lt, w_lt;
  logic             w_bit_a, w_bit_b;

  assign w_bit_a = r_a[r_idx];
  assign w_bit_b = r_b[r_idx];

  always_comb begin
    w_state = r_state;
    w_a     = r_a;
    w_b     = r_b;
    w_idx   = r_idx;
    w_eq_c  = r_eq_c;
    w_gt_c  = r_gt_c;
    w_lt_c  = r_lt_c;
    w_eq    = r_eq;
    w_gt    = r_gt;
    w_lt    = r_lt;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_a     = i_a;
          w_b     = i_b;
          w_idx   = IdxW'(WIDTH - 1);
          w_eq_c  = 1'b1;
          w_gt_c  = 1'b0;
          w_lt_c  = 1'b0;
          w_state = StRun;
        end
      end
      StRun: begin
        // First differing bit from the MSB decides; later bits cannot override it.
        if (!r_gt_c && !r_lt_c) begin
          if (w_bit_a && !w_bit_b) begin
            w_gt_c = 1'b1;
            w_eq_c = 1'b0;
          end else if (!w_bit_a && w_bit_b) begin
            w_lt_c = 1'b1;
            w_eq_c = 1'b0;
          end
        end
        if (r_idx == '0) begin
          // Result registers load on DONE entry so they line up with the done pulse.
          w_eq    = w_eq_c;
          w_gt    = w_gt_c;
          w_lt    = w_lt_c;
          w_state = StDone;
        end else begin
          w_idx = r_idx - IdxW'(1);
        end
      end
      StDone: begin
        w_state = StIdle;
      end
      default: begin
        w_state = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_eq_c  <= 1'b0;
      r_gt_c  <= 1'b0;
      r_lt_c  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_a     <= w_a;
      r_b     <= w_b;
      r_idx   <= w_idx;
      r_eq_c  <= w_eq_c;
      r_gt_c  <= w_gt_c;
      r_lt_c  <= w_lt_c;
      r_eq    <= w_eq;
      r_gt    <= w_gt;
      r_lt    <= w_lt;
    end
  end

  assign o_busy = (r_state == StRun);
  assign o_done = (r_state == StDone);
  assign o_eq   = r_eq;
  assign o_gt   = r_gt;
  assign o_lt   = r_lt;

endmodule
